// File: rtl/usb_pd_pkg.sv
// ---------------------------------------------------------------------------
// usb_pd_pkg
// Shared USB Power Delivery definitions used by the protocol-layer receive
// path: message-type codes, header bit positions, specification-revision
// encodings, the receive FSM state type and two header-building helpers.
// ---------------------------------------------------------------------------
package usb_pd_pkg;

  // Message types recognised by the receive classifier
  localparam logic [4:0] MT_GOODCRC    = 5'h01;
  localparam logic [4:0] MT_SOFT_RESET = 5'h0D;

  // Message header field positions
  localparam int HDR_EXT_BIT   = 15;
  localparam int HDR_NUM_LSB   = 12;
  localparam int HDR_ID_LSB    = 9;
  localparam int HDR_ROLE_BIT  = 8;
  localparam int HDR_REV_LSB   = 6;
  localparam int HDR_DROLE_BIT = 5;

  // Maximum number of 32-bit data objects in one packet
  localparam int NUM_WORDS = 7;

  // Specification-revision field encodings
  typedef enum logic [1:0] {
    SPEC_REV_10 = 2'b00,
    SPEC_REV_20 = 2'b01,
    SPEC_REV_30 = 2'b10
  } spec_rev_e;

  // Receive FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLASS = 2'b01,
    S_REQ   = 2'b10
  } prl_rx_state_e;

  // Header of the GoodCRC reply acknowledging MessageID id
  function automatic logic [15:0] goodcrc_hdr(input logic [2:0] id,
                                              input logic       pwr_role,
                                              input logic [1:0] spec_rev,
                                              input logic       data_role);
    logic [15:0] h;
    h                   = 16'h0000;
    h[4:0]              = MT_GOODCRC;
    h[HDR_DROLE_BIT]    = data_role;
    h[HDR_REV_LSB +: 2] = spec_rev;
    h[HDR_ROLE_BIT]     = pwr_role;
    h[HDR_ID_LSB +: 3]  = id;
    return h;
  endfunction

  // Header handed to the policy engine: {ext,num,id,role,3'b000,type}
  function automatic logic [15:0] msg_hdr(input logic       ext,
                                          input logic [2:0] num,
                                          input logic [2:0] id,
                                          input logic       role,
                                          input logic [4:0] typ);
    logic [15:0] h;
    h                   = 16'h0000;
    h[4:0]              = typ;
    h[HDR_ROLE_BIT]     = role;
    h[HDR_ID_LSB +: 3]  = id;
    h[HDR_NUM_LSB +: 3] = num;
    h[HDR_EXT_BIT]      = ext;
    return h;
  endfunction

endpackage

// File: rtl/usb_pd_prl_rx_if.sv
// ---------------------------------------------------------------------------
// usb_pd_prl_rx_if
// Bundles the protocol-layer receive signals:
//   rx_*          decoded packet from the PD PHY receiver
//   tx_req/hdr    GoodCRC request towards the TX PHY, tx_ack its acceptance
//   msg_*         valid/ready buffer towards the policy engine
//   goodcrc_*, soft_reset_rx, overflow   status towards the policy engine
// Modport slave is the receive block, master is its environment.
// ---------------------------------------------------------------------------
interface usb_pd_prl_rx_if;
  import usb_pd_pkg::*;

  logic        rx_role;
  logic [2:0]  rx_id;
  logic [2:0]  rx_num;
  logic [4:0]  rx_type;
  logic        rx_ext;
  logic [31:0] rx_word [NUM_WORDS];
  logic        rx_crc_ok;
  logic        rx_pkg_valid;

  logic        tx_req;
  logic [15:0] tx_hdr;
  logic        tx_ack;

  logic        msg_valid;
  logic        msg_ready;
  logic [15:0] msg_hdr;
  logic [31:0] msg_word [NUM_WORDS];

  logic        goodcrc_rx;
  logic [2:0]  goodcrc_id;
  logic        soft_reset_rx;
  logic        overflow;

  modport slave (
    input  rx_role, rx_id, rx_num, rx_type, rx_ext, rx_word, rx_crc_ok, rx_pkg_valid,
    input  tx_ack, msg_ready,
    output tx_req, tx_hdr, msg_valid, msg_hdr, msg_word,
    output goodcrc_rx, goodcrc_id, soft_reset_rx, overflow
  );

  modport master (
    output rx_role, rx_id, rx_num, rx_type, rx_ext, rx_word, rx_crc_ok, rx_pkg_valid,
    output tx_ack, msg_ready,
    input  tx_req, tx_hdr, msg_valid, msg_hdr, msg_word,
    input  goodcrc_rx, goodcrc_id, soft_reset_rx, overflow
  );

endinterface

// File: rtl/usb_pd_msg_buf.sv
// ---------------------------------------------------------------------------
// usb_pd_msg_buf
// Single-entry valid/ready holding register for one received message.
//   clock, nrst  clock and asynchronous active-low reset
//   load         capture hdr_in/word_in and raise valid (wins over a consume)
//   ready        consumer takes the message when valid & ready
//   valid/hdr/word  held message; fields stay stable while valid is high
// ---------------------------------------------------------------------------
module usb_pd_msg_buf
  import usb_pd_pkg::*;
(
  input  logic        clock,
  input  logic        nrst,
  input  logic        load,
  input  logic [15:0] hdr_in,
  input  logic [31:0] word_in [NUM_WORDS],
  input  logic        ready,
  output logic        valid,
  output logic [15:0] hdr,
  output logic [31:0] word [NUM_WORDS]
);

  logic        valid_q, valid_d;
  logic [15:0] hdr_q, hdr_d;
  logic [31:0] word_q [NUM_WORDS];
  logic [31:0] word_d [NUM_WORDS];

  // Next-state: load has priority, otherwise a handshake empties the entry
  always_comb begin
    valid_d = valid_q;
    hdr_d   = hdr_q;
    word_d  = word_q;
    if (load) begin
      valid_d = 1'b1;
      hdr_d   = hdr_in;
      word_d  = word_in;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register with asynchronous clear
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      hdr_q   <= 16'h0000;
      word_q  <= '{default: 32'h0000_0000};
    end else begin
      valid_q <= valid_d;
      hdr_q   <= hdr_d;
      word_q  <= word_d;
    end
  end

  assign valid = valid_q;
  assign hdr   = hdr_q;
  assign word  = word_q;

endmodule

// File: rtl/usb_pd_prl_rx.sv
// ---------------------------------------------------------------------------
// usb_pd_prl_rx
// Protocol-layer receive stage. Captures CRC-good packets on the rising edge
// of rx_pkg_valid, classifies them (GoodCRC, Soft_Reset, duplicate, overflow,
// new), requests a GoodCRC reply from the TX PHY and, once the reply is
// accepted, hands new messages to the policy engine through usb_pd_msg_buf.
//   clock, nrst  system clock and asynchronous active-low reset
//   bus          usb_pd_prl_rx_if.slave, carrying all packet, reply,
//                delivery and status signals
// Parameters: system_khz and TX_TIMEOUT_US set the reply timeout in clocks;
// PORT_PWR_ROLE, PORT_DATA_ROLE and SPEC_REV fill the GoodCRC header.
// ---------------------------------------------------------------------------
module usb_pd_prl_rx
  import usb_pd_pkg::*;
#(
  parameter int unsigned system_khz     = 200000,
  parameter int unsigned TX_TIMEOUT_US  = 195,
  parameter logic        PORT_PWR_ROLE  = 1'b0,
  parameter logic        PORT_DATA_ROLE = 1'b0,
  parameter logic [1:0]  SPEC_REV       = SPEC_REV_30
)
(
  input  logic           clock,
  input  logic           nrst,
  usb_pd_prl_rx_if.slave bus
);

  localparam int unsigned LIMIT = system_khz * TX_TIMEOUT_US / 1000;
  localparam int          TW    = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] LIMIT_C = TW'(LIMIT);

  prl_rx_state_e state_q, state_d;
  logic          pkg_valid_dly_q, pkg_valid_dly_d;
  logic          cap_role_q, cap_role_d;
  logic [2:0]    cap_id_q, cap_id_d;
  logic [2:0]    cap_num_q, cap_num_d;
  logic [4:0]    cap_type_q, cap_type_d;
  logic          cap_ext_q, cap_ext_d;
  logic [31:0]   cap_word_q [NUM_WORDS];
  logic [31:0]   cap_word_d [NUM_WORDS];
  logic [2:0]    stored_id_q, stored_id_d;
  logic          stored_vld_q, stored_vld_d;
  logic          deliver_q, deliver_d;
  logic          load_q, load_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tx_req_q, tx_req_d;
  logic [15:0]   tx_hdr_q, tx_hdr_d;
  logic          goodcrc_rx_q, goodcrc_rx_d;
  logic [2:0]    goodcrc_id_q, goodcrc_id_d;
  logic          soft_reset_rx_q, soft_reset_rx_d;
  logic          overflow_q, overflow_d;

  logic          rise_s;
  logic          reply_s;
  logic [15:0]   load_hdr_s;
  logic [31:0]   load_word_s [NUM_WORDS];
  logic          buf_valid_s;
  logic [15:0]   buf_hdr_s;
  logic [31:0]   buf_word_s [NUM_WORDS];

  assign rise_s = bus.rx_pkg_valid & ~pkg_valid_dly_q;

  // Delivered header and payload; words beyond the object count read as zero
  always_comb begin
    load_hdr_s = msg_hdr(cap_ext_q, cap_num_q, cap_id_q, cap_role_q, cap_type_q);
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (3'(i) < cap_num_q) begin
        load_word_s[i] = cap_word_q[i];
      end else begin
        load_word_s[i] = 32'h0000_0000;
      end
    end
  end

  // FSM next state, classifier, timer and reply/status outputs
  always_comb begin
    state_d         = state_q;
    pkg_valid_dly_d = bus.rx_pkg_valid;
    cap_role_d      = cap_role_q;
    cap_id_d        = cap_id_q;
    cap_num_d       = cap_num_q;
    cap_type_d      = cap_type_q;
    cap_ext_d       = cap_ext_q;
    cap_word_d      = cap_word_q;
    stored_id_d     = stored_id_q;
    stored_vld_d    = stored_vld_q;
    deliver_d       = deliver_q;
    load_d          = 1'b0;
    timer_d         = timer_q;
    tx_req_d        = tx_req_q;
    tx_hdr_d        = tx_hdr_q;
    goodcrc_rx_d    = 1'b0;
    goodcrc_id_d    = goodcrc_id_q;
    soft_reset_rx_d = 1'b0;
    overflow_d      = overflow_q;
    reply_s         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Rises outside S_IDLE are never looked at, so a busy FSM ignores them
        if (rise_s && bus.rx_crc_ok) begin
          cap_role_d = bus.rx_role;
          cap_id_d   = bus.rx_id;
          cap_num_d  = bus.rx_num;
          cap_type_d = bus.rx_type;
          cap_ext_d  = bus.rx_ext;
          cap_word_d = bus.rx_word;
          state_d    = S_CLASS;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLASS: begin
        if ((cap_type_q == MT_GOODCRC) && (cap_num_q == 3'd0)) begin
          goodcrc_rx_d = 1'b1;
          goodcrc_id_d = cap_id_q;
        end else if ((cap_type_q == MT_SOFT_RESET) && (cap_num_q == 3'd0)) begin
          stored_vld_d    = 1'b0;
          soft_reset_rx_d = 1'b1;
          deliver_d       = 1'b0;
          reply_s         = 1'b1;
        end else if (stored_vld_q && (cap_id_q == stored_id_q)) begin
          deliver_d = 1'b0;
          reply_s   = 1'b1;
        end else if (buf_valid_s) begin
          // No reply: the sender times out and retries once the buffer drains
          overflow_d = 1'b1;
        end else begin
          deliver_d = 1'b1;
          reply_s   = 1'b1;
        end

        if (reply_s) begin
          state_d  = S_REQ;
          timer_d  = {TW{1'b0}};
          tx_req_d = 1'b1;
          tx_hdr_d = goodcrc_hdr(cap_id_q, PORT_PWR_ROLE, SPEC_REV, PORT_DATA_ROLE);
        end else begin
          state_d = S_IDLE;
        end
      end

      S_REQ: begin
        // tx_ack is tested first so it wins over a simultaneous timeout
        if (bus.tx_ack) begin
          tx_req_d = 1'b0;
          tx_hdr_d = 16'h0000;
          load_d   = deliver_q;
          state_d  = S_IDLE;
          // MessageID is only remembered once the reply is actually on its way
          if (deliver_q) begin
            stored_id_d  = cap_id_q;
            stored_vld_d = 1'b1;
          end else begin
            stored_id_d  = stored_id_q;
          end
        end else if (timer_q == LIMIT_C) begin
          tx_req_d = 1'b0;
          tx_hdr_d = 16'h0000;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1'b1);
          state_d = S_REQ;
        end
      end

      default: begin
        tx_req_d = 1'b0;
        tx_hdr_d = 16'h0000;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q         <= S_IDLE;
      pkg_valid_dly_q <= 1'b0;
      cap_role_q      <= 1'b0;
      cap_id_q        <= 3'd0;
      cap_num_q       <= 3'd0;
      cap_type_q      <= 5'h00;
      cap_ext_q       <= 1'b0;
      cap_word_q      <= '{default: 32'h0000_0000};
      stored_id_q     <= 3'd0;
      stored_vld_q    <= 1'b0;
      deliver_q       <= 1'b0;
      load_q          <= 1'b0;
      timer_q         <= {TW{1'b0}};
      tx_req_q        <= 1'b0;
      tx_hdr_q        <= 16'h0000;
      goodcrc_rx_q    <= 1'b0;
      goodcrc_id_q    <= 3'd0;
      soft_reset_rx_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pkg_valid_dly_q <= pkg_valid_dly_d;
      cap_role_q      <= cap_role_d;
      cap_id_q        <= cap_id_d;
      cap_num_q       <= cap_num_d;
      cap_type_q      <= cap_type_d;
      cap_ext_q       <= cap_ext_d;
      cap_word_q      <= cap_word_d;
      stored_id_q     <= stored_id_d;
      stored_vld_q    <= stored_vld_d;
      deliver_q       <= deliver_d;
      load_q          <= load_d;
      timer_q         <= timer_d;
      tx_req_q        <= tx_req_d;
      tx_hdr_q        <= tx_hdr_d;
      goodcrc_rx_q    <= goodcrc_rx_d;
      goodcrc_id_q    <= goodcrc_id_d;
      soft_reset_rx_q <= soft_reset_rx_d;
      overflow_q      <= overflow_d;
    end
  end

  usb_pd_msg_buf u_msg_buf (
    .clock   (clock),
    .nrst    (nrst),
    .load    (load_q),
    .hdr_in  (load_hdr_s),
    .word_in (load_word_s),
    .ready   (bus.msg_ready),
    .valid   (buf_valid_s),
    .hdr     (buf_hdr_s),
    .word    (buf_word_s)
  );

  assign bus.tx_req        = tx_req_q;
  assign bus.tx_hdr        = tx_hdr_q;
  assign bus.msg_valid     = buf_valid_s;
  assign bus.msg_hdr       = buf_hdr_s;
  assign bus.msg_word      = buf_word_s;
  assign bus.goodcrc_rx    = goodcrc_rx_q;
  assign bus.goodcrc_id    = goodcrc_id_q;
  assign bus.soft_reset_rx = soft_reset_rx_q;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_usb_pd_prl_rx.sv
// ---------------------------------------------------------------------------
// tb_usb_pd_prl_rx
// Self-checking bench for usb_pd_prl_rx. A packet-level reference model
// (remembered MessageID, one-entry mailbox, sticky overflow) predicts the
// outcome of every packet; each test task compares the observed reply,
// status pulses and delivered message against that prediction.
// ---------------------------------------------------------------------------
module tb_usb_pd_prl_rx;

  localparam int LIMIT = 200000 * 195 / 1000;

  logic clock = 1'b0;
  logic nrst  = 1'b0;

  usb_pd_prl_rx_if bus ();

  usb_pd_prl_rx #(
    .system_khz     (200000),
    .TX_TIMEOUT_US  (195),
    .PORT_PWR_ROLE  (1'b0),
    .PORT_DATA_ROLE (1'b0),
    .SPEC_REV       (2'b10)
  ) dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          mdl_stored;
  bit          mdl_full;
  bit          mdl_ovf;
  logic [15:0] mdl_hdr;
  logic [31:0] mdl_word [7];

  // per-packet prediction and observation
  bit          exp_reply, exp_gc, exp_sr;
  logic [15:0] exp_txhdr;
  int          obs_req, obs_gc, obs_sr;
  logic [15:0] obs_txhdr;
  logic [2:0]  obs_gcid;
  logic [31:0] pkt_word [7];

  task automatic idle_inputs();
    bus.rx_role = 1'b0; bus.rx_id = 3'd0; bus.rx_num = 3'd0; bus.rx_type = 5'h00;
    bus.rx_ext = 1'b0; bus.rx_crc_ok = 1'b0; bus.rx_pkg_valid = 1'b0;
    bus.tx_ack = 1'b0; bus.msg_ready = 1'b0;
    for (int i = 0; i < 7; i++) bus.rx_word[i] = 32'h0;
  endtask

  task automatic model_reset();
    mdl_stored = -1; mdl_full = 1'b0; mdl_ovf = 1'b0; mdl_hdr = 16'h0;
    for (int i = 0; i < 7; i++) mdl_word[i] = 32'h0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 7; i++) pkt_word[i] = $urandom;
  endtask

  // Predict, drive one packet, acknowledge the reply after ack_delay cycles
  // of tx_req (negative: never), observe everything, then update the model.
  task automatic run_pkt(input logic [4:0] typ, input logic [2:0] id, input logic [2:0] num,
                         input logic role, input logic ext, input logic crc, input int ack_delay);
    bit is_new;
    bit ack_done;
    int budget;
    int vlen;
    exp_reply = 1'b0; exp_gc = 1'b0; exp_sr = 1'b0; is_new = 1'b0;
    exp_txhdr = 16'((int'(id) << 9) | (2 << 6) | 1);
    if (crc) begin
      if (typ == 5'h01 && num == 3'd0) exp_gc = 1'b1;
      else if (typ == 5'h0D && num == 3'd0) begin exp_sr = 1'b1; exp_reply = 1'b1; mdl_stored = -1; end
      else if (mdl_stored == int'(id)) exp_reply = 1'b1;
      else if (mdl_full) mdl_ovf = 1'b1;
      else begin exp_reply = 1'b1; is_new = 1'b1; end
    end
    bus.rx_type = typ; bus.rx_id = id; bus.rx_num = num; bus.rx_role = role;
    bus.rx_ext = ext; bus.rx_crc_ok = crc;
    for (int i = 0; i < 7; i++) bus.rx_word[i] = pkt_word[i];
    budget = (exp_reply && ack_delay < 0) ? LIMIT + 40 : 40 + ((ack_delay > 0) ? ack_delay : 0);
    vlen = $urandom_range(1, 3);
    obs_req = 0; obs_gc = 0; obs_sr = 0; obs_txhdr = 16'h0; obs_gcid = 3'd0; ack_done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      bus.rx_pkg_valid = (c < vlen);
      if (ack_delay >= 0 && !ack_done && obs_req == ack_delay + 1) begin
        bus.tx_ack = 1'b1; ack_done = 1'b1;
      end else begin
        bus.tx_ack = 1'b0;
      end
      @(negedge clock);
      if (bus.tx_req) begin obs_req++; obs_txhdr = bus.tx_hdr; end
      if (bus.goodcrc_rx) begin obs_gc++; obs_gcid = bus.goodcrc_id; end
      if (bus.soft_reset_rx) obs_sr++;
    end
    bus.tx_ack = 1'b0;
    if (is_new && ack_delay >= 0) begin
      mdl_stored = int'(id);
      mdl_full = 1'b1;
      mdl_hdr = 16'(int'(ext) * 32768 + int'(num) * 4096 + int'(id) * 512 + int'(role) * 256 + int'(typ));
      for (int i = 0; i < 7; i++) mdl_word[i] = (i < int'(num)) ? pkt_word[i] : 32'h0;
    end
  endtask

  task automatic do_consume();
    bus.msg_ready = 1'b1;
    @(posedge clock); #1;
    bus.msg_ready = 1'b0;
    mdl_full = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    idle_inputs();
    model_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus.tx_req !== 1'b0 || bus.tx_hdr !== 16'h0) begin errors++; $display("FAIL reset_tx: tx_req=%b tx_hdr=%h required 0/0000", bus.tx_req, bus.tx_hdr); end
    checks++; if (bus.msg_valid !== 1'b0 || bus.msg_hdr !== 16'h0 || bus.msg_word[0] !== 32'h0) begin errors++; $display("FAIL reset_msg: valid=%b hdr=%h w0=%h required 0", bus.msg_valid, bus.msg_hdr, bus.msg_word[0]); end
    checks++; if (bus.goodcrc_rx !== 1'b0 || bus.goodcrc_id !== 3'd0 || bus.soft_reset_rx !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_status: gc=%b id=%0d sr=%b ovf=%b required 0", bus.goodcrc_rx, bus.goodcrc_id, bus.soft_reset_rx, bus.overflow); end
    nrst = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (bus.tx_req !== 1'b0 || bus.msg_valid !== 1'b0) begin errors++; $display("FAIL reset_release: tx_req=%b msg_valid=%b required 0", bus.tx_req, bus.msg_valid); end
  endtask

  task automatic test_data_msg();
    rand_words();
    pkt_word[0] = 32'h0001_912C;
    run_pkt(5'h01, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1, 10);
    checks++; if (obs_req < 11 || obs_req > 13) begin errors++; $display("FAIL data_req: tx_req cycles=%0d required 11..13", obs_req); end
    checks++; if (obs_txhdr !== exp_txhdr) begin errors++; $display("FAIL data_txhdr: got %h required %h", obs_txhdr, exp_txhdr); end
    checks++; if (bus.msg_valid !== 1'b1 || bus.msg_hdr !== mdl_hdr) begin errors++; $display("FAIL data_msg: valid=%b hdr=%h required 1/%h", bus.msg_valid, bus.msg_hdr, mdl_hdr); end
    checks++; if (bus.msg_word[0] !== 32'h0001_912C || bus.msg_word[1] !== 32'h0) begin errors++; $display("FAIL data_words: w0=%h w1=%h required 0001912c/0", bus.msg_word[0], bus.msg_word[1]); end
  endtask

  task automatic test_duplicate();
    rand_words();
    run_pkt(5'h01, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1, 3);
    checks++; if (obs_req == 0 || obs_txhdr !== exp_txhdr) begin errors++; $display("FAIL dup_reply: cycles=%0d hdr=%h required >0/%h", obs_req, obs_txhdr, exp_txhdr); end
    checks++; if (bus.msg_valid !== 1'b1 || bus.msg_hdr !== mdl_hdr || bus.msg_word[0] !== mdl_word[0]) begin errors++; $display("FAIL dup_buffer: valid=%b hdr=%h w0=%h required 1/%h/%h", bus.msg_valid, bus.msg_hdr, bus.msg_word[0], mdl_hdr, mdl_word[0]); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL dup_ovf: got %b required 0", bus.overflow); end
    do_consume();
    checks++; if (bus.msg_valid !== 1'b0) begin errors++; $display("FAIL consume: msg_valid=%b required 0", bus.msg_valid); end
  endtask

  task automatic test_soft_reset();
    rand_words();
    run_pkt(5'h0D, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5);
    checks++; if (obs_sr != 1 || obs_req == 0) begin errors++; $display("FAIL sr_pulse: pulses=%0d req=%0d required 1/>0", obs_sr, obs_req); end
    checks++; if (bus.msg_valid !== 1'b0) begin errors++; $display("FAIL sr_nodeliver: msg_valid=%b required 0", bus.msg_valid); end
    rand_words();
    run_pkt(5'h02, 3'd2, 3'd3, 1'b1, 1'b0, 1'b1, 4);
    checks++; if (bus.msg_valid !== 1'b1 || bus.msg_hdr !== mdl_hdr || bus.msg_word[2] !== mdl_word[2] || bus.msg_word[3] !== 32'h0) begin errors++; $display("FAIL sr_newmsg: valid=%b hdr=%h required 1/%h", bus.msg_valid, bus.msg_hdr, mdl_hdr); end
    do_consume();
  endtask

  task automatic test_crc_bad();
    rand_words();
    run_pkt(5'h03, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 2);
    checks++; if (obs_req != 0 || obs_gc != 0 || obs_sr != 0) begin errors++; $display("FAIL crc_bad: req=%0d gc=%0d sr=%0d required 0", obs_req, obs_gc, obs_sr); end
    checks++; if (bus.msg_valid !== 1'b0) begin errors++; $display("FAIL crc_bad_msg: msg_valid=%b required 0", bus.msg_valid); end
  endtask

  task automatic test_timeout();
    rand_words();
    run_pkt(5'h04, 3'd4, 3'd2, 1'b0, 1'b1, 1'b1, -1);
    checks++; if (obs_req < LIMIT - 2 || obs_req > LIMIT + 3) begin errors++; $display("FAIL timeout_len: tx_req cycles=%0d required %0d..%0d", obs_req, LIMIT - 2, LIMIT + 3); end
    checks++; if (bus.tx_req !== 1'b0 || bus.msg_valid !== 1'b0) begin errors++; $display("FAIL timeout_drop: tx_req=%b msg_valid=%b required 0/0", bus.tx_req, bus.msg_valid); end
    rand_words();
    run_pkt(5'h04, 3'd4, 3'd2, 1'b0, 1'b1, 1'b1, 2);
    checks++; if (bus.msg_valid !== 1'b1 || bus.msg_hdr !== mdl_hdr) begin errors++; $display("FAIL timeout_resend: valid=%b hdr=%h required 1/%h", bus.msg_valid, bus.msg_hdr, mdl_hdr); end
  endtask

  task automatic test_overflow();
    rand_words();
    run_pkt(5'h03, 3'd3, 3'd2, 1'b0, 1'b0, 1'b1, 5);
    checks++; if (obs_req != 0 || bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf: req=%0d overflow=%b required 0/1", obs_req, bus.overflow); end
    checks++; if (bus.msg_hdr !== mdl_hdr || bus.msg_word[1] !== mdl_word[1]) begin errors++; $display("FAIL ovf_buffer: hdr=%h required %h", bus.msg_hdr, mdl_hdr); end
    rand_words();
    run_pkt(5'h01, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 5);
    checks++; if (obs_gc != 1 || obs_gcid !== 3'd5 || obs_req != 0) begin errors++; $display("FAIL goodcrc: pulses=%0d id=%0d req=%0d required 1/5/0", obs_gc, obs_gcid, obs_req); end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    bus.rx_type = 5'h02; bus.rx_id = 3'd4; bus.rx_num = 3'd0; bus.rx_crc_ok = 1'b1;
    @(posedge clock); #1 bus.rx_pkg_valid = 1'b1;
    @(posedge clock); #1 bus.rx_pkg_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (bus.tx_req) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL areset_req: tx_req not seen within 20 cycles"); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (bus.tx_req !== 1'b0 || bus.msg_valid !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL areset_clear: tx_req=%b msg_valid=%b ovf=%b required 0", bus.tx_req, bus.msg_valid, bus.overflow); end
    idle_inputs();
    model_reset();
    @(negedge clock);
    nrst = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_random();
    logic [4:0] typ;
    logic [2:0] num;
    bit words_ok;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0: begin typ = 5'h01; num = 3'd0; end
        1: begin typ = 5'h0D; num = 3'd0; end
        default: begin typ = 5'($urandom_range(2, 31)); num = 3'($urandom_range(0, 7)); end
      endcase
      rand_words();
      run_pkt(typ, 3'($urandom_range(0, 3)), num, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 5) != 0), $urandom_range(0, 12));
      checks++; if ((obs_req > 0) != exp_reply || (exp_reply && obs_txhdr !== exp_txhdr)) begin errors++; $display("FAIL rnd%0d_reply: req=%0d hdr=%h required reply=%0d hdr=%h", n, obs_req, obs_txhdr, exp_reply, exp_txhdr); end
      checks++; if (obs_gc != int'(exp_gc) || (exp_gc && obs_gcid !== bus.rx_id) || obs_sr != int'(exp_sr)) begin errors++; $display("FAIL rnd%0d_pulses: gc=%0d id=%0d sr=%0d required %0d/%0d/%0d", n, obs_gc, obs_gcid, obs_sr, exp_gc, bus.rx_id, exp_sr); end
      words_ok = 1'b1;
      for (int i = 0; i < 7; i++) if (mdl_full && bus.msg_word[i] !== mdl_word[i]) words_ok = 1'b0;
      checks++; if (bus.msg_valid !== mdl_full || (mdl_full && (bus.msg_hdr !== mdl_hdr || !words_ok))) begin errors++; $display("FAIL rnd%0d_msg: valid=%b hdr=%h required %b/%h words_ok=%b", n, bus.msg_valid, bus.msg_hdr, mdl_full, mdl_hdr, words_ok); end
      checks++; if (bus.overflow !== mdl_ovf) begin errors++; $display("FAIL rnd%0d_ovf: got %b required %b", n, bus.overflow, mdl_ovf); end
      if ($urandom_range(0, 1) == 1) do_consume();
    end
  endtask

  initial begin
    test_reset();
    test_data_msg();
    test_duplicate();
    test_soft_reset();
    test_crc_bad();
    test_timeout();
    test_overflow();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
